// File: rtl/aes_decrypt_core.sv
// aes_decrypt_core: iterative AES-128 inverse cipher, one round per clock, valid/ready output.
// Define AES_DEC_ABORT_EN to add the `abort` input that cancels a block in flight.
module aes_decrypt_core (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  output logic         in_ready,
  input  logic [127:0] cipher_in,
  output logic [3:0]   key_idx,
  input  logic [127:0] round_key,
  output logic [127:0] plain_out,
  output logic         out_valid,
`ifdef AES_DEC_ABORT_EN
  input  logic         abort,
`endif
  input  logic         out_ready
);

  typedef enum logic [1:0] {S_IDLE, S_ROUND, S_FINAL, S_DONE} fsm_e;

  fsm_e         fsm_q, fsm_d;
  logic [127:0] state_q, state_d;
  logic [3:0]   key_idx_q, key_idx_d;
  logic [127:0] round_out;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] p;
    acc = 8'h00;
    p   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ p;
      p = xtime(p);
    end
    return acc;
  endfunction

  // Undo the S-box affine map, then invert in GF(2^8) as s^254 (0 maps to 0).
  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    logic [7:0] s;
    logic [7:0] p;
    logic [7:0] r;
    s = {b[1:0], b[7:2]} ^ {b[4:0], b[7:5]} ^ {b[6:0], b[7]} ^ 8'h05;
    p = s;
    r = 8'h01;
    for (int i = 1; i < 8; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

  // Byte n sits at [127-8n -: 8]; matrix element (row r, col c) is byte r+4c.
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c-r+4)%4)) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    for (int n = 0; n < 16; n++)
      o[127-8*n -: 8] = inv_sbox(s[127-8*n -: 8]);
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a [4];
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) a[r] = s[127-8*(r+4*c) -: 8];
      for (int r = 0; r < 4; r++)
        o[127-8*(r+4*c) -: 8] = gf_mul(a[r], 8'h0e) ^ gf_mul(a[(r+1)%4], 8'h0b) ^
                                gf_mul(a[(r+2)%4], 8'h0d) ^ gf_mul(a[(r+3)%4], 8'h09);
    end
    return o;
  endfunction

  always_comb begin
    // NOTE: every variable gets its hold value first so no path can infer a latch.
    fsm_d     = fsm_q;
    state_d   = state_q;
    key_idx_d = key_idx_q;
    round_out = inv_sub_bytes(inv_shift_rows(state_q)) ^ round_key;

    unique case (fsm_q)
      S_IDLE: begin
        if (start) begin
          state_d   = cipher_in ^ round_key;
          key_idx_d = 4'd9;
          fsm_d     = S_ROUND;
        end
      end
      S_ROUND: begin
        state_d = inv_mix_columns(round_out);
        if (key_idx_q <= 4'd1) begin
          key_idx_d = 4'd0;
          fsm_d     = S_FINAL;
        end else begin
          key_idx_d = key_idx_q - 4'd1;
        end
      end
      S_FINAL: begin
        state_d = round_out;
        fsm_d   = S_DONE;
      end
      S_DONE: begin
        if (out_ready) begin
          key_idx_d = 4'd10;
          fsm_d     = S_IDLE;
        end
      end
      default: fsm_d = S_IDLE;
    endcase

`ifdef AES_DEC_ABORT_EN
    // Abort wins over the output handshake; in IDLE it is a no-op.
    if (abort && (fsm_q != S_IDLE)) begin
      fsm_d     = S_IDLE;
      state_d   = '0;
      key_idx_d = 4'd10;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q     <= S_IDLE;
      state_q   <= '0;
      key_idx_q <= 4'd10;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values of the others.
      fsm_q     <= fsm_d;
      state_q   <= state_d;
      key_idx_q <= key_idx_d;
    end
  end

  assign in_ready  = (fsm_q == S_IDLE);
  assign out_valid = (fsm_q == S_DONE);
  assign plain_out = state_q;
  assign key_idx   = key_idx_q;

endmodule
